pool_window_core: RTL and testbench
===================================

POOL_WINDOW_CORE -- requirements
Module: pool_window

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  window and window_size valid this cycle.
REQ-005 window_size  input  16  unsigned side length N of the square window.
REQ-006 window  input  400  25 signed Q5.11 entries; entry i occupies bits [16*i+15 : 16*i], row-major, i = 0..24.
REQ-007 value  output  16  signed Q5.11 pooled result, registered.
REQ-008 out_valid  output  1  value updated this cycle.

Function
REQ-009 Number format: 16-bit two's complement with 11 fractional bits (0x0400 = 0.5, 0x0800 = 1.0, 0xF000 = -2.0).
REQ-010 Effective size: Neff = window_size clamped to 5 when window_size > 5; Neff = 0 when window_size = 0.
REQ-011 Active entries: indices 0 .. Neff*Neff-1; all other entries excluded regardless of content.
REQ-012 Sum: signed sum of active entries, each sign-extended to at least 21 bits; no intermediate overflow.
REQ-013 Scale: result = sum arithmetically shifted right by 2 (fixed divide by 4, rounding toward negative infinity), independent of window_size.
REQ-014 Saturation: result > 32767 gives 0x7FFF; result < -32768 gives 0x8000; otherwise the low 16 bits.
REQ-015 Neff = 0 yields value 0x0000.
REQ-016 Latency: on a rising edge with in_valid = 1, value takes the result computed from that cycle's inputs and out_valid = 1 for exactly that following cycle.
REQ-017 With in_valid = 0, value holds its previous content and out_valid = 0.
REQ-018 Back-to-back in_valid SHALL be accepted every cycle (throughput 1 per clock); no backpressure.
REQ-019 The datapath between input and register is purely combinational; no multicycle state machine.

Reset
REQ-020 rst_n low SHALL immediately clear value to 0x0000 and out_valid to 0, independent of clk.
REQ-021 An in_valid sampled while rst_n is low is discarded; the first result follows the first valid edge after release.
REQ-022 Reset asserted mid-stream discards any pending result.

Verification
REQ-023 window_size=2, entries 0..3 = 0x0400, rest 0 -> value 0x0400 (0.5), out_valid pulse one cycle.
REQ-024 window_size=3, entries 0..3 = 0x0800,0x0C00,0xFC00,0xF000, rest 0 -> value 0x0000.
REQ-025 window_size=5, entries 0..3 = 0x3400,0x1400,0x8400,0x0700, rest 0 -> value 0xF4C0 (-1.40625).
REQ-026 window_size=5, entries 0..3 = 0x2400,0x0430,0x1400,0x0400, rest 0 -> value 0x100C (2.005859375).
REQ-027 window_size=2 with entry 4 = 0x7FFF -> entry ignored, value from entries 0..3 only; window_size=0 -> 0x0000.
REQ-028 window_size=5, all 0x7FFF -> 0x7FFF; all 0x8000 -> 0x8000; rst_n pulsed low between in_valid cycles -> value 0x0000, out_valid 0 asynchronously.

Source files
------------

// File: rtl/pool_window_core.sv
// Pools a 5x5 Q5.11 window into one saturated Q5.11 value: active-entry sum divided by 4.
// One-cycle latency, one result per clock, no backpressure.
module pool_window_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [15:0]  window_size,
  input  logic [399:0] window,
  output logic [15:0]  value,
  output logic         out_valid
);

  logic [2:0]         neff;
  logic [4:0]         n_active;
  logic signed [15:0] entry;
  logic signed [20:0] sum;
  logic signed [20:0] scaled;
  logic [15:0]        result;

  always_comb begin
    neff     = (window_size > 16'd5) ? 3'd5 : window_size[2:0];
    n_active = {2'b00, neff} * {2'b00, neff};
    entry    = '0;
    sum      = '0;
    // Only the leading Neff*Neff row-major entries contribute; the rest are ignored.
    for (int i = 0; i < 25; i++) begin
      entry = window[16*i +: 16];
      if (5'(i) < n_active) begin
        sum = sum + 21'(entry);
      end
    end
    scaled = sum >>> 2;
    if (scaled > 21'sd32767) begin
      result = 16'h7FFF;
    end else if (scaled < -21'sd32768) begin
      result = 16'h8000;
    end else begin
      result = scaled[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        value <= result;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_core.sv
// Directed bench for pool_window_core with hand-computed expected results.
module tb_pool_window_core;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [15:0]  window_size;
  logic [399:0] window;
  logic [15:0]  value;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  pool_window_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .window_size (window_size),
    .window      (window),
    .value       (value),
    .out_valid   (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [399:0] win4(input logic [15:0] e0, input logic [15:0] e1,
                                        input logic [15:0] e2, input logic [15:0] e3);
    logic [399:0] w;
    w = '0;
    w[15:0]  = e0;
    w[31:16] = e1;
    w[47:32] = e2;
    w[63:48] = e3;
    return w;
  endfunction

  function automatic logic [399:0] fill(input logic [15:0] e);
    logic [399:0] w;
    for (int i = 0; i < 25; i++) w[16*i +: 16] = e;
    return w;
  endfunction

  // Entered 1 time unit after a rising edge; leaves at the same phase.
  task automatic run(input string tag, input logic [15:0] n, input logic [399:0] w,
                     input logic [15:0] exp);
    window_size = n;
    window      = w;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_value"}, value, exp);
    check({tag, "_ovld"}, {15'd0, out_valid}, 16'd1);
    @(posedge clk); #1;
    check({tag, "_ovld_drop"}, {15'd0, out_valid}, 16'd0);
    check({tag, "_hold"}, value, exp);
  endtask

  logic [399:0] w;

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    window_size = 16'd2;
    window      = win4(16'h0400, 16'h0400, 16'h0400, 16'h0400);
    #1;
    check("reset_value", value, 16'h0000);
    check("reset_ovld", {15'd0, out_valid}, 16'd0);
    @(posedge clk); #1;
    check("reset_discard_value", value, 16'h0000);
    check("reset_discard_ovld", {15'd0, out_valid}, 16'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    check("idle_ovld", {15'd0, out_valid}, 16'd0);

    run("half",   16'd2, win4(16'h0400, 16'h0400, 16'h0400, 16'h0400), 16'h0400);
    run("zero3",  16'd3, win4(16'h0800, 16'h0C00, 16'hFC00, 16'hF000), 16'h0000);
    run("neg5",   16'd5, win4(16'h3400, 16'h1400, 16'h8400, 16'h0700), 16'hF4C0);
    run("pos5",   16'd5, win4(16'h2400, 16'h0430, 16'h1400, 16'h0400), 16'h100C);

    w = win4(16'h0400, 16'h0400, 16'h0400, 16'h0400);
    w[79:64] = 16'h7FFF;
    run("excl4",  16'd2, w, 16'h0400);
    run("size0",  16'd0, fill(16'h7FFF), 16'h0000);
    run("satpos", 16'd5, fill(16'h7FFF), 16'h7FFF);
    run("satneg", 16'd5, fill(16'h8000), 16'h8000);
    run("clamp",  16'd300, fill(16'h0800), 16'h3200);
    run("floorp", 16'd1, win4(16'h0802, 16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h0200);
    run("floorn", 16'd1, win4(16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 16'hFFFF);

    w = fill(16'h0800);
    for (int i = 16; i < 25; i++) w[16*i +: 16] = 16'h7FFF;
    run("size4",  16'd4, w, 16'h2000);

    // Back-to-back accepts on consecutive edges.
    window_size = 16'd2;
    window      = win4(16'h0400, 16'h0400, 16'h0400, 16'h0400);
    in_valid    = 1'b1;
    @(posedge clk); #1;
    check("b2b_first", value, 16'h0400);
    window_size = 16'd1;
    window      = win4(16'hF000, 16'h0000, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    check("b2b_second", value, 16'hFC00);
    check("b2b_ovld", {15'd0, out_valid}, 16'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_drop", {15'd0, out_valid}, 16'd0);

    // Mid-cycle reset with a result in flight and in_valid held high.
    window_size = 16'd5;
    window      = fill(16'h7FFF);
    in_valid    = 1'b1;
    @(posedge clk); #2;
    check("pre_rst_value", value, 16'h7FFF);
    rst_n = 1'b0;
    #1;
    check("async_rst_value", value, 16'h0000);
    check("async_rst_ovld", {15'd0, out_valid}, 16'd0);
    @(posedge clk); #1;
    check("rst_hold_value", value, 16'h0000);
    check("rst_hold_ovld", {15'd0, out_valid}, 16'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ovld", {15'd0, out_valid}, 16'd0);
    run("recover", 16'd2, win4(16'h0400, 16'h0400, 16'h0400, 16'h0400), 16'h0400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
